image_decimator: RTL and testbench
==================================

IMAGE_DECIMATOR -- requirements
Module: image_decimator

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter NCH, default 3, channels per pixel.
REQ-003 SHALL have parameter STEP, default 48, decimation pitch in both axes, >=2.
REQ-004 SHALL have parameters CROP_X0, CROP_Y0, defaults 160, 0, source coordinate of first stored sample.
REQ-005 SHALL have parameters OUT_W, OUT_H, defaults 20, 20, stored samples per row and rows; DEPTH = OUT_W*OUT_H, AW = clog2(DEPTH).
REQ-006 CLK  in  1  sole clock, all logic on rising edge.
REQ-007 RST_N  in  1  reset, asynchronous, active-low.
REQ-008 START  in  1  one-cycle pulse arming capture of the next frame.
REQ-009 FRAME_SYNC  in  1  one-cycle pulse marking the first pixel of a source frame.
REQ-010 PIX_VALID  in  1  qualifies PIX_IN, X_Cont, Y_Cont this cycle.
REQ-011 X_Cont, Y_Cont  in  16 each  source pixel column and row.
REQ-012 PIX_IN  in  NCH*PIX_W  pixel, channel 0 in LSBs.
REQ-013 RD_EN  in  1  read request.
REQ-014 RD_ADDR  in  AW  read address, row-major (row*OUT_W+col).
REQ-015 RD_DATA  out  NCH*PIX_W  read data.
REQ-016 RD_VALID  out  1  RD_DATA qualifier.
REQ-017 BUSY  out  1  capture in progress.
REQ-018 DONE  out  1  level, buffer holds a complete frame.

Function
REQ-019 SHALL implement states IDLE, ARMED, CAPTURE, FULL.
REQ-020 IDLE->ARMED on START; ARMED->CAPTURE on FRAME_SYNC; CAPTURE->FULL after the DEPTH-th write; FULL->ARMED on START.
REQ-021 START in ARMED or CAPTURE SHALL be ignored; FRAME_SYNC outside ARMED SHALL be ignored, including a second FRAME_SYNC in CAPTURE.
REQ-022 In CAPTURE, a sample SHALL be written when PIX_VALID=1, X_Cont=CROP_X0+c*STEP for c<OUT_W, and Y_Cont=CROP_Y0+r*STEP for r<OUT_H.
REQ-023 Sample selection SHALL use column/row phase counters compared against STEP; no divide or modulo operators.
REQ-024 Write address SHALL be generated internally as r*OUT_W+c via an incrementing counter reset on entry to CAPTURE.
REQ-025 Pixels outside the crop window, or with PIX_VALID=0, SHALL not write.
REQ-026 Reads SHALL have latency one: RD_EN at cycle n gives RD_DATA and RD_VALID=1 at n+1; RD_VALID=0 otherwise.
REQ-027 Reads SHALL be permitted in every state; RD_ADDR>=DEPTH returns zero with RD_VALID=1.
REQ-028 Simultaneous read and write to the same address SHALL return the old contents.
REQ-029 BUSY=1 in ARMED and CAPTURE; DONE=1 only in FULL; both registered.
REQ-030 If the frame ends (FRAME_SYNC not required) with fewer than DEPTH writes, state SHALL remain CAPTURE until DEPTH writes complete on later frames' matching pixels.

Reset
REQ-031 RST_N low SHALL force IDLE, write counter 0, BUSY=0, DONE=0, RD_VALID=0, RD_DATA=0, asynchronously.
REQ-032 Buffer contents SHALL not be reset.
REQ-033 Reset during CAPTURE SHALL abandon the frame; START is needed afterwards.

Configuration
REQ-034 With macro IMAGE_DECIMATOR_AVG_EN defined, each stored sample SHALL be the per-channel mean (sum>>1, truncating) of the pixel at the selected coordinate and the pixel at X_Cont+1 on the same row, written one valid-pixel later.
REQ-035 Without IMAGE_DECIMATOR_AVG_EN, the pixel at the selected coordinate SHALL be stored unmodified.
REQ-036 With IMAGE_DECIMATOR_AVG_EN, the last column SHALL satisfy CROP_X0+(OUT_W-1)*STEP+1 within the source row; ports are identical in both builds.

Verification
REQ-037 START, FRAME_SYNC, raster 1280x960 with PIX_IN={X_Cont[7:0],Y_Cont[7:0],8'h5A} -> DONE=1 after pixel (1072,912); RD_ADDR=0 -> {8'hA0,8'h00,8'h5A}; RD_ADDR=21 -> {8'hD0,8'h30,8'h5A}.
REQ-038 FRAME_SYNC with no prior START -> no writes, BUSY=0, DONE=0.
REQ-039 RST_N low at pixel (400,96) of capture -> BUSY=0, DONE=0 immediately; new START+frame -> DONE=1.
REQ-040 RD_EN with RD_ADDR=400 -> RD_DATA=0, RD_VALID=1 one cycle later.
REQ-041 PIX_VALID=0 at (160,0) then valid -> address 0 keeps prior value; DONE never asserts for that frame.
REQ-042 AVG build, PIX_IN channel 0 = 10 at (160,0), 13 at (161,0) -> address 0 channel 0 = 11.

Source files
------------

// File: rtl/image_decimator.sv
`default_nettype none
// ============================================================================
// Module   : image_decimator
// Purpose  : Captures a STEP-pitch decimated crop of one video frame into an
//            on-chip buffer and serves row-major reads with one-cycle latency.
//            Define IMAGE_DECIMATOR_AVG_EN to store the mean of each selected
//            pixel and its right-hand neighbour instead of the raw pixel.
// Revision : 1.0 - initial release
// ============================================================================
module image_decimator #(
    parameter int PIX_W   = 8,
    parameter int NCH     = 3,
    parameter int STEP    = 48,
    parameter int CROP_X0 = 160,
    parameter int CROP_Y0 = 0,
    parameter int OUT_W   = 20,
    parameter int OUT_H   = 20,
    localparam int DEPTH  = OUT_W * OUT_H,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 FRAME_SYNC,
    input  logic                 PIX_VALID,
    input  logic [15:0]          X_Cont,
    input  logic [15:0]          Y_Cont,
    input  logic [NCH*PIX_W-1:0] PIX_IN,
    input  logic                 RD_EN,
    input  logic [AW-1:0]        RD_ADDR,
    output logic [NCH*PIX_W-1:0] RD_DATA,
    output logic                 RD_VALID,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int c_DW = NCH * PIX_W;
    localparam int c_CW = $clog2(OUT_W + 1);
    localparam int c_RW = $clog2(OUT_H + 1);

    localparam logic [15:0]     c_X0        = 16'(CROP_X0);
    localparam logic [15:0]     c_Y0        = 16'(CROP_Y0);
    localparam logic [15:0]     c_STEP      = 16'(STEP);
    localparam logic [c_CW-1:0] c_LAST_COL  = c_CW'(OUT_W - 1);
    localparam logic [c_RW-1:0] c_ROWS      = c_RW'(OUT_H);
    localparam logic [AW-1:0]   c_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]     c_DEPTH     = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FULL    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_busy;
    logic              r_done;

    logic [15:0]       r_tx;
    logic [15:0]       r_ty;
    logic [c_CW-1:0]   r_col;
    logic [c_RW-1:0]   r_row;
    logic [AW-1:0]     r_wr_addr;

    logic              w_capt;
    logic              w_hit;
    logic              w_we;
    logic              w_last_wr;
    logic [c_DW-1:0]   w_wdata;

    logic [c_DW-1:0]   r_mem [DEPTH];

    // The sync pixel itself belongs to the new frame, so it is eligible too.
    assign w_capt = (r_state == S_CAPTURE) || ((r_state == S_ARMED) && FRAME_SYNC);

    assign w_hit = w_capt && PIX_VALID && (r_row < c_ROWS) &&
                   (X_Cont == r_tx) && (Y_Cont == r_ty);

    // Next wanted source coordinate, stepped by STEP after every selected pixel.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx  <= c_X0;
            r_ty  <= c_Y0;
            r_col <= '0;
            r_row <= '0;
        end else if (!w_capt) begin
            r_tx  <= c_X0;
            r_ty  <= c_Y0;
            r_col <= '0;
            r_row <= '0;
        end else if (w_hit) begin
            if (r_col == c_LAST_COL) begin
                r_col <= '0;
                r_tx  <= c_X0;
                r_row <= r_row + c_RW'(1);
                r_ty  <= r_ty + c_STEP;
            end else begin
                r_col <= r_col + c_CW'(1);
                r_tx  <= r_tx + c_STEP;
            end
        end
    end

`ifdef IMAGE_DECIMATOR_AVG_EN
    logic              r_pend;
    logic [c_DW-1:0]   r_hold;

    // Selected pixel is held until the next valid pixel, its right neighbour.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend <= 1'b0;
            r_hold <= '0;
        end else if (!w_capt) begin
            r_pend <= 1'b0;
        end else if (PIX_VALID) begin
            r_pend <= w_hit;
            if (w_hit) begin
                r_hold <= PIX_IN;
            end
        end
    end

    assign w_we = w_capt && PIX_VALID && r_pend;

    for (genvar g = 0; g < NCH; g++) begin : g_avg_ch
        assign w_wdata[g*PIX_W +: PIX_W] =
            PIX_W'(({1'b0, r_hold[g*PIX_W +: PIX_W]} +
                    {1'b0, PIX_IN[g*PIX_W +: PIX_W]}) >> 1);
    end
`else
    assign w_we    = w_hit;
    assign w_wdata = PIX_IN;
`endif

    assign w_last_wr = w_we && (r_wr_addr == c_LAST_ADDR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_addr <= '0;
        end else if (!w_capt) begin
            r_wr_addr <= '0;
        end else if (w_we) begin
            r_wr_addr <= w_last_wr ? '0 : r_wr_addr + AW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (FRAME_SYNC) w_state_nxt = w_last_wr ? S_FULL : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_last_wr) w_state_nxt = S_FULL;
            end
            S_FULL: begin
                if (START) w_state_nxt = S_ARMED;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
            r_done  <= (w_state_nxt == S_FULL);
        end
    end

    assign BUSY = r_busy;
    assign DONE = r_done;

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[r_wr_addr] <= w_wdata;
        end
    end

    // Read samples the array before this edge's write lands: old data wins.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            RD_VALID <= RD_EN;
            if (RD_EN) begin
                RD_DATA <= ({1'b0, RD_ADDR} < c_DEPTH) ? r_mem[RD_ADDR] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_decimator.sv
`default_nettype none
// Bench for image_decimator at default parameters: sparse rasters carrying only
// the pixels that matter, a coordinate-level reference model and literal pins.
module tb_image_decimator;

    localparam int PIX_W = 8;
    localparam int NCH   = 3;
    localparam int DW    = NCH * PIX_W;
    localparam int STEP  = 48;
    localparam int X0    = 160;
    localparam int Y0    = 0;
    localparam int OUT_W = 20;
    localparam int OUT_H = 20;
    localparam int DEPTH = OUT_W * OUT_H;
    localparam int AW    = 9;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic          FRAME_SYNC = 1'b0;
    logic          PIX_VALID = 1'b0;
    logic [15:0]   X_Cont = '0;
    logic [15:0]   Y_Cont = '0;
    logic [DW-1:0] PIX_IN = '0;
    logic          RD_EN = 1'b0;
    logic [AW-1:0] RD_ADDR = '0;
    logic [DW-1:0] RD_DATA;
    logic          RD_VALID;
    logic          BUSY;
    logic          DONE;

    image_decimator dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .FRAME_SYNC (FRAME_SYNC),
        .PIX_VALID  (PIX_VALID),
        .X_Cont     (X_Cont),
        .Y_Cont     (Y_Cont),
        .PIX_IN     (PIX_IN),
        .RD_EN      (RD_EN),
        .RD_ADDR    (RD_ADDR),
        .RD_DATA    (RD_DATA),
        .RD_VALID   (RD_VALID),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0b required %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %06h required %06h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (coordinate arithmetic) ----------------
    int            m_state = 0;   // 0 idle, 1 armed, 2 capturing, 3 full
    int            m_k     = 0;   // selected pixels seen this capture
    int            m_nwr   = 0;   // buffer writes this capture
    bit            m_pend  = 1'b0;
    logic [DW-1:0] m_hold  = '0;
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic          exp_rv   = 1'b0;
    logic [DW-1:0] exp_rd   = '0;
    bit            exp_rk   = 1'b1;

    function automatic logic [DW-1:0] mean2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] m;
        int s;
        m = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            s = int'(a[ch*PIX_W +: PIX_W]) + int'(b[ch*PIX_W +: PIX_W]);
            m[ch*PIX_W +: PIX_W] = PIX_W'(s / 2);
        end
        return m;
    endfunction

    task automatic m_write(input logic [DW-1:0] d);
        m_mem[m_nwr]   = d;
        m_known[m_nwr] = 1'b1;
        m_nwr++;
    endtask

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            m_state = 0; m_k = 0; m_nwr = 0; m_pend = 1'b0;
            exp_rv = 1'b0; exp_rd = '0; exp_rk = 1'b1;
        end else begin
            bit capt, hit, full_now;
            int ex, ey;
            if (RD_EN) begin
                if (int'(RD_ADDR) >= DEPTH) begin
                    exp_rd = '0; exp_rk = 1'b1;
                end else begin
                    exp_rd = m_mem[RD_ADDR]; exp_rk = m_known[RD_ADDR];
                end
            end
            exp_rv = RD_EN;
            if (m_state != 2) begin
                m_k = 0; m_nwr = 0; m_pend = 1'b0;
            end
            capt     = (m_state == 2) || (m_state == 1 && FRAME_SYNC);
            full_now = 1'b0;
            if (capt && PIX_VALID) begin
                ex  = X0 + (m_k % OUT_W) * STEP;
                ey  = Y0 + (m_k / OUT_W) * STEP;
                hit = (m_k < DEPTH) && (int'(X_Cont) == ex) && (int'(Y_Cont) == ey);
`ifdef IMAGE_DECIMATOR_AVG_EN
                if (m_pend) m_write(mean2(m_hold, PIX_IN));
                m_pend = hit;
                if (hit) m_hold = PIX_IN;
`else
                if (hit) m_write(PIX_IN);
`endif
                if (hit) m_k++;
                full_now = (m_nwr == DEPTH);
            end
            case (m_state)
                0:       if (START) m_state = 1;
                1:       if (FRAME_SYNC) m_state = full_now ? 3 : 2;
                2:       if (full_now) m_state = 3;
                default: if (START) m_state = 1;
            endcase
        end
        exp_busy = (m_state == 1) || (m_state == 2);
        exp_done = (m_state == 3);
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge CLK);
        chk1("busy", BUSY, exp_busy);
        chk1("done", DONE, exp_done);
        chk1("rd_valid", RD_VALID, exp_rv);
        if (exp_rv && exp_rk) chkd("rd_data", RD_DATA, exp_rd);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "bench did not finish");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int x, input int y, input logic [7:0] c0);
        return {8'(x), 8'(y), c0};
    endfunction

    task automatic pix(input int x, input int y, input bit v, input logic [DW-1:0] d,
                       input bit fs, input bit st);
        X_Cont = 16'(x); Y_Cont = 16'(y); PIX_VALID = v; PIX_IN = d;
        FRAME_SYNC = fs; START = st;
        tick();
        FRAME_SYNC = 1'b0; START = 1'b0;
    endtask

    task automatic idle(input int n);
        PIX_VALID = 1'b0; FRAME_SYNC = 1'b0; START = 1'b0; RD_EN = 1'b0;
        repeat (n) tick();
    endtask

    task automatic start_pulse();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
    endtask

    task automatic rd(input int a, input logic [DW-1:0] e, input string nm);
        RD_EN = 1'b1; RD_ADDR = AW'(a);
        tick();
        RD_EN = 1'b0;
        chk1({nm, "_valid"}, RD_VALID, 1'b1);
        chkd(nm, RD_DATA, e);
        tick();
        chk1({nm, "_valid_drop"}, RD_VALID, 1'b0);
    endtask

    // Sparse raster: sync pixel, per-row distractors, each grid pixel and its
    // right neighbour, plus an invalid pixel and an off-grid row sample.
    task automatic frame(input logic [7:0] c0, input bit noise, input bit drop_first,
                         input bit rst_mid, input bit collide, input bit expect_done,
                         input logic [DW-1:0] old0);
        pix(0, 0, 1'b1, pat(0, 0, c0), 1'b1, 1'b0);
        for (int r = 0; r < OUT_H; r++) begin
            int y;
            y = Y0 + r * STEP;
            pix(0, y, 1'b1, pat(0, y, c0), noise && (r == 5), noise && (r == 3));
            for (int c = 0; c < OUT_W; c++) begin
                int x;
                bit first, last;
                x     = X0 + c * STEP;
                first = (r == 0) && (c == 0);
                last  = (r == OUT_H - 1) && (c == OUT_W - 1);
                if (rst_mid && x == 400 && y == 96) begin
                    X_Cont = 16'(x); Y_Cont = 16'(y); PIX_VALID = 1'b1; PIX_IN = pat(x, y, c0);
                    #2 RST_N = 1'b0;
                    #1;
                    chk1("rst_busy", BUSY, 1'b0);
                    chk1("rst_done", DONE, 1'b0);
                    chk1("rst_rd_valid", RD_VALID, 1'b0);
                    chkd("rst_rd_data", RD_DATA, '0);
                    tick();
                    tick();
                    RST_N = 1'b1; PIX_VALID = 1'b0;
                    return;
                end
                if (expect_done && last) chk1("done_before_last", DONE, 1'b0);
`ifndef IMAGE_DECIMATOR_AVG_EN
                if (collide && first) begin RD_EN = 1'b1; RD_ADDR = '0; end
`endif
                pix(x, y, !(drop_first && first), pat(x, y, c0), 1'b0, 1'b0);
                RD_EN = 1'b0;
                if (expect_done && last) begin
`ifdef IMAGE_DECIMATOR_AVG_EN
                    chk1("done_wait_neighbour", DONE, 1'b0);
`else
                    chk1("done_after_last", DONE, 1'b1);
`endif
                end
`ifdef IMAGE_DECIMATOR_AVG_EN
                if (collide && first) begin RD_EN = 1'b1; RD_ADDR = '0; end
`endif
                pix(x + 1, y, 1'b1, pat(x + 1, y, c0), 1'b0, 1'b0);
                RD_EN = 1'b0;
                if (collide && first) chkd("rw_same_addr_old", RD_DATA, old0);
                if (expect_done && last) chk1("done_after_pair", DONE, 1'b1);
                pix(x + 2, y, 1'b0, pat(x + 2, y, c0), 1'b0, 1'b0);
            end
            pix(X0, y + 1, 1'b1, pat(X0, y + 1, c0), 1'b0, 1'b0);
        end
        pix(1279, 959, 1'b1, pat(1279, 959, c0), 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        chk1("reset_busy", BUSY, 1'b0);
        chk1("reset_done", DONE, 1'b0);
        chk1("reset_rd_valid", RD_VALID, 1'b0);
        chkd("reset_rd_data", RD_DATA, '0);
        RST_N = 1'b1;
        idle(2);

        // Frame without START: nothing armed.
        frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        chk1("nostart_busy", BUSY, 1'b0);
        chk1("nostart_done", DONE, 1'b0);

        // Full capture with ignored START / FRAME_SYNC inside the frame.
        start_pulse();
        chk1("armed_busy", BUSY, 1'b1);
        chk1("armed_done", DONE, 1'b0);
        frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle(2);
        chk1("full_busy", BUSY, 1'b0);
        chk1("full_done", DONE, 1'b1);
        rd(0,   24'hA0005A, "rd_addr0");
        rd(21,  24'hD0305A, "rd_addr21");
        rd(399, 24'h30905A, "rd_addr399");
        rd(400, 24'h000000, "rd_addr400");
        rd(511, 24'h000000, "rd_addr511");

        // Recapture, reading address 0 on the cycle it is rewritten.
        start_pulse();
        frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'hA0005A);
        idle(2);
        rd(0, 24'hA00077, "rd_addr0_new");

        // First sample invalid: capture stalls, address 0 untouched.
        start_pulse();
        frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        chk1("drop_done", DONE, 1'b0);
        chk1("drop_busy", BUSY, 1'b1);
        rd(0, 24'hA00077, "rd_addr0_kept");

        // Reset in the middle of a capture, then a clean capture.
        do_reset();
        start_pulse();
        frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(2);
        chk1("post_rst_busy", BUSY, 1'b0);
        chk1("post_rst_done", DONE, 1'b0);
        start_pulse();
        frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle(2);
        chk1("recapture_done", DONE, 1'b1);

        // Neighbour pair with distinct channel-0 values at the first sample.
        start_pulse();
        pix(0, 0, 1'b1, pat(0, 0, 8'h00), 1'b1, 1'b0);
        pix(160, 0, 1'b1, {8'hA0, 8'h00, 8'd10}, 1'b0, 1'b0);
        pix(161, 0, 1'b1, {8'hA1, 8'h00, 8'd13}, 1'b0, 1'b0);
        idle(2);
`ifdef IMAGE_DECIMATOR_AVG_EN
        rd(0, 24'hA0000B, "avg_addr0");
`else
        rd(0, 24'hA0000A, "raw_addr0");
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
